// File: rtl/gpmc_pad_io_if.sv
// gpmc_pad_io_if: fabric-side bundle of the pad bank.
// The fabric is the master; the pad cell is the slave.
interface gpmc_pad_io_if #(
    parameter int WIDTH = 16
);
    logic             clock_enable;
    logic             output_enable;
    logic [WIDTH-1:0] d_out_0;
    logic [WIDTH-1:0] d_in_0;

    modport master (
        output clock_enable,
        output output_enable,
        output d_out_0,
        input  d_in_0
    );

    modport slave (
        input  clock_enable,
        input  output_enable,
        input  d_out_0,
        output d_in_0
    );
endinterface

// File: rtl/gpmc_pad_io.sv
// gpmc_pad_io: SB_IO-style SDR bidirectional pad bank.
// Input, output data and output enable are each combinational or registered.
module gpmc_pad_io #(
    parameter int         WIDTH    = 16,
    parameter logic [5:0] PIN_TYPE = 6'b101001,
    parameter bit         PULLUP   = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    inout  wire [WIDTH-1:0] package_pin,
    gpmc_pad_io_if.slave    bus
);
    localparam logic [1:0] IN_MODE  = PIN_TYPE[1:0];
    localparam logic [1:0] OUT_MODE = PIN_TYPE[3:2];
    localparam logic [1:0] OE_MODE  = PIN_TYPE[5:4];

    logic [WIDTH-1:0] in_reg;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] pad_data;
    logic             oe_reg;
    logic             drive;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_reg  <= '0;
            out_reg <= '0;
            oe_reg  <= 1'b0;
        end else if (bus.clock_enable) begin
            in_reg  <= package_pin;
            out_reg <= bus.d_out_0;
            oe_reg  <= bus.output_enable;
        end
    end

    // Output mode 00 (DDR) is not supported and falls back to registered.
    always_comb begin
        pad_data = out_reg;
        drive    = 1'b0;
        case (OUT_MODE)
            2'b10:   pad_data = bus.d_out_0;
            2'b11:   pad_data = ~out_reg;
            default: pad_data = out_reg;
        endcase
        case (OE_MODE)
            2'b00:   drive = 1'b0;
            2'b01:   drive = 1'b1;
            2'b10:   drive = bus.output_enable;
            default: drive = oe_reg;
        endcase
    end

    assign package_pin = drive ? pad_data : {WIDTH{1'bz}};
    assign bus.d_in_0  = (IN_MODE == 2'b01) ? package_pin : in_reg;

    // Weak pull only resolves floating pins; any real driver wins.
    if (PULLUP) begin : g_pull
        pullup pu_pin (package_pin);
    end
endmodule

// File: tb/tb_gpmc_pad_io.sv
// tb_gpmc_pad_io: scoreboard bench over six pad banks,
// one per PIN_TYPE/PULLUP combination of interest.
module tb_gpmc_pad_io;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    wire [15:0] p1, p2, p3, p4, p5, p6;
    logic        e1_en = 1'b0, e5_en = 1'b0, e6_en = 1'b0;
    logic [15:0] e1_val = '0, e5_val = '0, e6_val = '0;

    assign p1 = e1_en ? e1_val : 16'bz;
    assign p5 = e5_en ? e5_val : 16'bz;
    assign p6 = e6_en ? e6_val : 16'bz;

    gpmc_pad_io_if #(.WIDTH(16)) b1 ();
    gpmc_pad_io_if #(.WIDTH(16)) b2 ();
    gpmc_pad_io_if #(.WIDTH(16)) b3 ();
    gpmc_pad_io_if #(.WIDTH(16)) b4 ();
    gpmc_pad_io_if #(.WIDTH(16)) b5 ();
    gpmc_pad_io_if #(.WIDTH(16)) b6 ();

    gpmc_pad_io #(.WIDTH(16), .PIN_TYPE(6'b101001), .PULLUP(1'b0))
        u1 (.clk(clk), .rst(rst), .package_pin(p1), .bus(b1.slave));
    gpmc_pad_io #(.WIDTH(16), .PIN_TYPE(6'b010100), .PULLUP(1'b0))
        u2 (.clk(clk), .rst(rst), .package_pin(p2), .bus(b2.slave));
    gpmc_pad_io #(.WIDTH(16), .PIN_TYPE(6'b110101), .PULLUP(1'b1))
        u3 (.clk(clk), .rst(rst), .package_pin(p3), .bus(b3.slave));
    gpmc_pad_io #(.WIDTH(16), .PIN_TYPE(6'b011101), .PULLUP(1'b0))
        u4 (.clk(clk), .rst(rst), .package_pin(p4), .bus(b4.slave));
    gpmc_pad_io #(.WIDTH(16), .PIN_TYPE(6'b101001), .PULLUP(1'b1))
        u5 (.clk(clk), .rst(rst), .package_pin(p5), .bus(b5.slave));
    gpmc_pad_io #(.WIDTH(16), .PIN_TYPE(6'b000000), .PULLUP(1'b1))
        u6 (.clk(clk), .rst(rst), .package_pin(p6), .bus(b6.slave));

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop(input logic [15:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check(e.tag, {16'h0, obs}, {16'h0, e.val});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] v;
        b1.clock_enable = 1'b1; b1.output_enable = 1'b0; b1.d_out_0 = '0;
        b2.clock_enable = 1'b1; b2.output_enable = 1'b0; b2.d_out_0 = '0;
        b3.clock_enable = 1'b1; b3.output_enable = 1'b0; b3.d_out_0 = '0;
        b4.clock_enable = 1'b1; b4.output_enable = 1'b0; b4.d_out_0 = '0;
        b5.clock_enable = 1'b1; b5.output_enable = 1'b0; b5.d_out_0 = '0;
        b6.clock_enable = 1'b1; b6.output_enable = 1'b0; b6.d_out_0 = '0;

        // Reset state
        tick();
        tick();
        push("rst_p2", 16'h0000);   pop(p2);
        push("rst_din2", 16'h0000); pop(b2.d_in_0);
        push("rst_p3", 16'hFFFF);   pop(p3);
        push("rst_p4", 16'hFFFF);   pop(p4);
        push("rst_din6", 16'h0000); pop(b6.d_in_0);
        rst = 1'b0;
        tick();

        // 1: combinational drive and readback, then release
        b1.output_enable = 1'b1;
        b1.d_out_0 = 16'hA5C3;
        #1;
        push("t1_pin", 16'hA5C3); pop(p1);
        push("t1_din", 16'hA5C3); pop(b1.d_in_0);
        b1.output_enable = 1'b0;
        e1_val = 16'h1234;
        e1_en = 1'b1;
        #1;
        push("t1_ext_din", 16'h1234); pop(b1.d_in_0);
        push("t1_ext_pin", 16'h1234); pop(p1);
        e1_en = 1'b0;

        // 2: registered out, always on, registered in
        tick();
        b2.d_out_0 = 16'h00FF;
        #1;
        push("t2_pin_pre", 16'h0000); pop(p2);
        tick();
        push("t2_pin_edge1", 16'h00FF); pop(p2);
        push("t2_din_edge1", 16'h0000); pop(b2.d_in_0);
        tick();
        push("t2_din_edge2", 16'h00FF); pop(b2.d_in_0);

        // 3: registered OE pulse, then async reset mid-drive
        b3.d_out_0 = 16'h1234;
        b3.output_enable = 1'b1;
        #1;
        push("t3_pin_pre", 16'hFFFF); pop(p3);
        tick();
        push("t3_pin_on", 16'h1234); pop(p3);
        push("t3_din_on", 16'h1234); pop(b3.d_in_0);
        b3.output_enable = 1'b0;
        #1;
        push("t3_pin_hold", 16'h1234); pop(p3);
        tick();
        push("t3_pin_off", 16'hFFFF); pop(p3);
        b3.output_enable = 1'b1;
        tick();
        push("t3_pin_redrive", 16'h1234); pop(p3);
        b3.output_enable = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        push("t3_rst_p3", 16'hFFFF);   pop(p3);
        push("t3_rst_p2", 16'h0000);   pop(p2);
        push("t3_rst_din2", 16'h0000); pop(b2.d_in_0);
        rst = 1'b0;
        tick();

        // 4: inverted registered output and clock_enable hold
        b4.d_out_0 = 16'h0F0F;
        #1;
        push("t4_pin_pre", 16'hFFFF); pop(p4);
        tick();
        push("t4_pin", 16'hF0F0); pop(p4);
        push("t4_din", 16'hF0F0); pop(b4.d_in_0);
        b4.clock_enable = 1'b0;
        b4.d_out_0 = 16'hFFFF;
        tick();
        push("t4_ce0_a", 16'hF0F0); pop(p4);
        tick();
        push("t4_ce0_b", 16'hF0F0); pop(p4);
        b4.clock_enable = 1'b1;
        tick();
        push("t4_ce1", 16'h0000); pop(p4);

        // 5: pull-up on a floating pin, overridden by external drive
        #1;
        push("t5_float", 16'hFFFF); pop(b5.d_in_0);
        e5_val = 16'h0000;
        e5_en = 1'b1;
        #1;
        push("t5_ext0", 16'h0000); pop(b5.d_in_0);
        e5_en = 1'b0;
        b5.output_enable = 1'b1;
        b5.d_out_0 = 16'h5A5A;
        #1;
        push("t5_drive", 16'h5A5A); pop(b5.d_in_0);

        // 6: never driven, registered input tracks external data
        tick();
        push("t6_float_pin", 16'hFFFF); pop(p6);
        push("t6_float_din", 16'hFFFF); pop(b6.d_in_0);
        e6_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            v = 16'($urandom);
            e6_val = v;
            b6.d_out_0 = ~v;
            b6.output_enable = i[0];
            push("t6_pin", v);
            #1;
            pop(p6);
            push("t6_din", v);
            tick();
            pop(b6.d_in_0);
        end
        e6_en = 1'b0;

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
